// File: rtl/cpu_hazard_unit_pkg.sv
// ============================================================================
//  Module      : cpu_pkg (package)
//  Description : Shared types and constants for the CPU hazard unit.
//                trk_entry_t describes one tracked post-decode pipeline stage.
//                The destination field is sized for the widest supported
//                register index (c_rd_max_w bits). Narrower indices are
//                zero-extended into it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  // Register index that never creates a hazard (hard-wired zero register).
  localparam int c_zero_reg_default = 31;

  // Widest register index held in a tracking entry. REG_ADDR_W must not exceed it.
  localparam int c_rd_max_w = 8;

  typedef struct packed {
    logic                  valid;
    logic [c_rd_max_w-1:0] rd;
    logic                  regwren;
    logic                  is_load;
  } trk_entry_t;

endpackage

`default_nettype wire

// File: rtl/cpu_hazard_match.sv
// ============================================================================
//  Module      : cpu_hazard_match
//  Description : Match and priority-encode for one decode source register
//                against the tracked post-decode stages. When several stages
//                match, the youngest one (smallest index) wins.
//  Ports       : i_src     - decode source register index
//                i_uses    - source is actually read by the instruction
//                i_trk     - tracking entries, stage 1 (EX) .. FWD_DEPTH
//                o_hit     - some stage matches
//                o_sel     - winning stage index (0 when no match)
//                o_is_load - winning stage holds a load
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_hazard_match
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH  = 2,
  parameter int ZERO_REG   = c_zero_reg_default,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic [REG_ADDR_W-1:0]  i_src,
  input  logic                   i_uses,
  input  trk_entry_t [FWD_DEPTH:1] i_trk,
  output logic                   o_hit,
  output logic [SEL_W-1:0]       o_sel,
  output logic                   o_is_load
);

  logic w_src_live;

  assign w_src_live = i_uses && (i_src != REG_ADDR_W'(ZERO_REG));

  // Scan oldest to youngest so that the youngest match is the last assignment.
  always_comb begin
    o_hit     = 1'b0;
    o_sel     = '0;
    o_is_load = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (w_src_live && i_trk[k].valid && i_trk[k].regwren &&
          (i_trk[k].rd == c_rd_max_w'(i_src))) begin
        o_hit     = 1'b1;
        o_sel     = SEL_W'(k);
        o_is_load = i_trk[k].is_load;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_hazard_unit.sv
// ============================================================================
//  Module      : cpu_hazard_unit
//  Description : Data-hazard detection for an in-order pipeline. It tracks
//                the destinations of the last FWD_DEPTH issued instructions.
//                It produces operand-forward selects and a load-use stall
//                combinationally from the decode-stage instruction.
//  Build macro : CPU_HAZARD_FORWARD_EN
//                  defined   - forwarding enabled. Only load-use hazards at
//                              stage <= LOAD_LAT stall.
//                  undefined - no forwarding. fwd_sel_a/b are tied to 0, and
//                              any match in any tracked stage stalls.
//  Parameters  : REG_ADDR_W (<= 8), FWD_DEPTH (1..4),
//                LOAD_LAT (0..FWD_DEPTH-1), ZERO_REG
//  Ports       : clk, reset (async, active high)
//                id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm,
//                id_rd, id_regwren, id_is_load - decode-stage instruction
//                flush       - kill the decode instruction this cycle
//                fwd_sel_a/b - 0 = register file, k = forward from stage k
//                stall       - hold fetch/decode, insert a bubble
//                stall_count - saturating count of stall cycles
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_hazard_unit
  import cpu_pkg::*;
#(
  parameter  int REG_ADDR_W = 5,
  parameter  int FWD_DEPTH  = 2,
  parameter  int LOAD_LAT   = 1,
  parameter  int ZERO_REG   = c_zero_reg_default,
  localparam int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rn,
  input  logic                  id_uses_rm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwren,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic [SEL_W-1:0]      fwd_sel_a,
  output logic [SEL_W-1:0]      fwd_sel_b,
  output logic                  stall,
  output logic [31:0]           stall_count
);

  trk_entry_t [FWD_DEPTH:1] r_trk;
  trk_entry_t               w_trk_in;
  logic [31:0]              r_stall_count;
  logic [31:0]              w_stall_count_nxt;
  logic                     w_hit_a;
  logic                     w_hit_b;
  logic                     w_load_a;
  logic                     w_load_b;
  logic [SEL_W-1:0]         w_sel_a;
  logic [SEL_W-1:0]         w_sel_b;
  logic                     w_stall;

  cpu_hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_DEPTH  (FWD_DEPTH),
    .ZERO_REG   (ZERO_REG),
    .SEL_W      (SEL_W)
  ) u_match_a (
    .i_src     (id_rn),
    .i_uses    (id_uses_rn),
    .i_trk     (r_trk),
    .o_hit     (w_hit_a),
    .o_sel     (w_sel_a),
    .o_is_load (w_load_a)
  );

  cpu_hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .FWD_DEPTH  (FWD_DEPTH),
    .ZERO_REG   (ZERO_REG),
    .SEL_W      (SEL_W)
  ) u_match_b (
    .i_src     (id_rm),
    .i_uses    (id_uses_rm),
    .i_trk     (r_trk),
    .o_hit     (w_hit_b),
    .o_sel     (w_sel_b),
    .o_is_load (w_load_b)
  );

`ifdef CPU_HAZARD_FORWARD_EN
  // Load data only becomes forwardable once the load is beyond stage LOAD_LAT.
  logic w_load_hz_a;
  logic w_load_hz_b;

  assign w_load_hz_a = w_hit_a && w_load_a && (int'(w_sel_a) <= LOAD_LAT);
  assign w_load_hz_b = w_hit_b && w_load_b && (int'(w_sel_b) <= LOAD_LAT);
  assign w_stall     = id_valid && !flush && (w_load_hz_a || w_load_hz_b);

  // A killed, stalled or absent instruction reads the register file.
  assign fwd_sel_a = (id_valid && !flush && !w_stall) ? w_sel_a : '0;
  assign fwd_sel_b = (id_valid && !flush && !w_stall) ? w_sel_b : '0;
`else
  // Without forwarding, wait until the writer has left the tracked window.
  logic w_unused_fwd;

  assign w_stall      = id_valid && !flush && (w_hit_a || w_hit_b);
  assign fwd_sel_a    = '0;
  assign fwd_sel_b    = '0;
  assign w_unused_fwd = ^{w_sel_a, w_sel_b, w_load_a, w_load_b, (LOAD_LAT != 0)};
`endif

  // A stalled or flushed decode instruction is replaced by a bubble.
  always_comb begin
    w_trk_in = '0;
    if (id_valid && !w_stall && !flush) begin
      w_trk_in.valid   = 1'b1;
      w_trk_in.rd      = c_rd_max_w'(id_rd);
      w_trk_in.regwren = id_regwren;
      w_trk_in.is_load = id_is_load;
    end
  end

  assign w_stall_count_nxt = (w_stall && (r_stall_count != 32'hFFFF_FFFF)) ?
                             r_stall_count + 32'd1 : r_stall_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trk         <= '0;
      r_stall_count <= '0;
    end else begin
      r_trk[1] <= w_trk_in;
      for (int k = 2; k <= FWD_DEPTH; k++) begin
        r_trk[k] <= r_trk[k-1];
      end
      r_stall_count <= w_stall_count_nxt;
    end
  end

  assign stall       = w_stall;
  assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: doc/cpu_hazard_unit.md
CPU_HAZARD_UNIT -- requirements
Module: cpu_hazard_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter FWD_DEPTH, default 2, number of tracked post-decode stages (1=EX … FWD_DEPTH); legal range 1..4.
REQ-003 SHALL have parameter LOAD_LAT, default 1, highest stage index at which load data is not yet forwardable; legal range 0..FWD_DEPTH-1.
REQ-004 SHALL have parameter ZERO_REG, default 31, register index that never creates a hazard.
REQ-005 SHALL derive SEL_W = $clog2(FWD_DEPTH+1).
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 id_valid  input  1  decode-stage instruction present.
REQ-009 id_rn, id_rm  input  REG_ADDR_W each  decode source registers A and B.
REQ-010 id_uses_rn, id_uses_rm  input  1 each  source actually read.
REQ-011 id_rd  input  REG_ADDR_W  decode destination register.
REQ-012 id_regwren, id_is_load  input  1 each  instruction writes rd; instruction is a load.
REQ-013 flush  input  1  taken branch: kill decode instruction this cycle.
REQ-014 fwd_sel_a, fwd_sel_b  output  SEL_W each  0 = register file, k = forward from stage k.
REQ-015 stall  output  1  hold fetch/decode, insert bubble.
REQ-016 stall_count  output  32  saturating count of stall cycles.

Function
REQ-017 SHALL hold tracking entries trk[1..FWD_DEPTH], each {valid, rd, regwren, is_load}.
REQ-018 Each clock, trk[1] SHALL load {1, id_rd, id_regwren, id_is_load} when id_valid && !stall && !flush, else an invalid bubble; trk[k+1] SHALL load trk[k].
REQ-019 Source S (A or B) SHALL match stage k when trk[k].valid && trk[k].regwren && trk[k].rd == S && S != ZERO_REG && the corresponding id_uses bit is 1.
REQ-020 On multiple matches the smallest k (youngest) SHALL win; no match SHALL give fwd_sel = 0.
REQ-021 Forward selects and stall SHALL be combinational from current inputs and trk (zero-cycle latency).
REQ-022 stall SHALL assert when id_valid && !flush and either source's winning match has is_load=1 and k <= LOAD_LAT.
REQ-023 While stall is asserted fwd_sel_a/b SHALL be 0.
REQ-024 flush SHALL take priority over stall: stall=0, bubble into trk[1]; older entries SHALL continue shifting.
REQ-025 stall_count SHALL increment by 1 on each clock where stall=1 and SHALL saturate at 32'hFFFF_FFFF.
REQ-026 id_valid=0 SHALL force stall=0 and fwd_sel_a/b=0.

Reset
REQ-027 reset SHALL asynchronously clear all trk entries to invalid, fwd_sel_a/b to 0, stall to 0 and stall_count to 0.
REQ-028 reset asserted mid-stall SHALL discard all in-flight hazards; first post-reset instruction SHALL see no matches.

Configuration
REQ-029 Macro CPU_HAZARD_FORWARD_EN defined: behaviour per REQ-019..REQ-024.
REQ-030 Macro CPU_HAZARD_FORWARD_EN undefined: fwd_sel_a/b SHALL be constant 0 and stall SHALL assert on any match at any k (load or not) until the writer leaves trk[FWD_DEPTH].

Structure
REQ-031 Package cpu_pkg SHALL hold the tracking-entry struct typedef and the ZERO_REG default constant.
REQ-032 Sub-module cpu_hazard_match SHALL implement one source's match/priority-encode and SHALL be instantiated twice (A, B).

Verification
REQ-033 ADD X1 issued, next cycle ADD X2,X1,X3 -> fwd_sel_a=1, stall=0.
REQ-034 ADD X1; NOP; SUB X4,X5,X1 -> fwd_sel_b=2, fwd_sel_a=0.
REQ-035 LDUR X7 then ADD X8,X7,X7 (LOAD_LAT=1) -> stall=1 one cycle, stall_count 0->1, then fwd_sel_a=fwd_sel_b=2.
REQ-036 ADD X31 then ADD X2,X31,X31 -> no forward, no stall; flush coincident with a load-use hazard -> stall=0, bubble enters trk[1].
REQ-037 reset asserted during load-use stall -> stall drops immediately, stall_count=0; forward-disabled build: ADD X1 then use X1 -> stall=1 for FWD_DEPTH cycles; stall_count preloaded near all-ones saturates at 32'hFFFF_FFFF.
